// File: rtl/scs8hd_lpflow_pwrseq_pkg.sv
// Shared types and defaults for the always-on power-gating sequencer.
package scs8hd_lpflow_pwrseq_pkg;

  localparam int unsigned ISO_CYC_DEF  = 2;
  localparam int unsigned SAVE_CYC_DEF = 2;
  localparam int unsigned RSTR_CYC_DEF = 2;
  localparam int unsigned TO_CYC_DEF   = 255;
  localparam int unsigned CW_DEF       = 8;
  localparam int unsigned NSTATE       = 8;

  typedef enum logic [NSTATE-1:0] {
    S_OFF     = 8'b0000_0001,
    S_SW_ON   = 8'b0000_0010,
    S_RESTORE = 8'b0000_0100,
    S_RST_REL = 8'b0000_1000,
    S_ON      = 8'b0001_0000,
    S_ISO     = 8'b0010_0000,
    S_SAVE    = 8'b0100_0000,
    S_SW_OFF  = 8'b1000_0000
  } pwrseq_state_e;

  typedef struct packed {
    logic sw_en;
    logic iso_en;
    logic save;
    logic restore;
    logic dom_resetb;
    logic pwr_on;
    logic busy;
  } pwrseq_out_t;

  localparam pwrseq_out_t OUT_OFF = '{sw_en: 1'b0, iso_en: 1'b1, save: 1'b0, restore: 1'b0,
                                      dom_resetb: 1'b0, pwr_on: 1'b0, busy: 1'b0};

endpackage

// File: rtl/scs8hd_lpflow_pwrseq_sync2.sv
// Two-flop synchroniser with async active-low reset to 0.
module scs8hd_lpflow_pwrseq_sync2 (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/scs8hd_lpflow_pwrseq_ctl.sv
// Power-gating sequencer: turns a level request into iso/save/switch/restore/reset ordering.
module scs8hd_lpflow_pwrseq_ctl
  import scs8hd_lpflow_pwrseq_pkg::*;
#(
  parameter int unsigned ISO_CYC  = ISO_CYC_DEF,
  parameter int unsigned SAVE_CYC = SAVE_CYC_DEF,
  parameter int unsigned RSTR_CYC = RSTR_CYC_DEF,
  parameter int unsigned TO_CYC   = TO_CYC_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic clk,
  input  logic resetb,
  input  logic pwr_req,
  input  logic sw_ack,
  output logic sw_en,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic dom_resetb,
  output logic pwr_on,
  output logic busy,
  output logic err_timeout
);

  // Each timed state exits on the cycle its counter shows LAST, so it lasts exactly N cycles.
  localparam logic [CW-1:0] ISO_LAST  = CW'(ISO_CYC - 1);
  localparam logic [CW-1:0] SAVE_LAST = CW'(SAVE_CYC - 1);
  localparam logic [CW-1:0] RSTR_LAST = CW'(RSTR_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  pwrseq_state_e state_q, state_d;
  pwrseq_out_t   out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          saved_q;
  logic          err_q;
  logic          sw_ack_s;
  logic          timeout_c;

  scs8hd_lpflow_pwrseq_sync2 u_sw_ack_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (sw_ack),
    .q      (sw_ack_s)
  );

  // State register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= S_OFF;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    timeout_c = 1'b0;
    case (state_q)
      S_OFF:     if (pwr_req) state_d = S_SW_ON;
      S_SW_ON: begin
        if (sw_ack_s) begin
          state_d = saved_q ? S_RESTORE : S_RST_REL;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_OFF;
          timeout_c = 1'b1;
        end
      end
      S_RESTORE: if (cnt_q == RSTR_LAST) state_d = S_RST_REL;
      S_RST_REL: state_d = S_ON;
      S_ON:      if (!pwr_req) state_d = S_ISO;
      S_ISO:     if (cnt_q == ISO_LAST) state_d = S_SAVE;
      S_SAVE:    if (cnt_q == SAVE_LAST) state_d = S_SW_OFF;
      S_SW_OFF: begin
        if (!sw_ack_s) begin
          state_d = S_OFF;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_OFF;
          timeout_c = 1'b1;
        end
      end
      default:   state_d = S_OFF;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with the state
  always_comb begin
    out_d = OUT_OFF;
    case (state_d)
      S_OFF:     out_d = OUT_OFF;
      S_SW_ON:   begin out_d.sw_en = 1'b1; out_d.busy = 1'b1; end
      S_RESTORE: begin out_d.sw_en = 1'b1; out_d.restore = 1'b1; out_d.busy = 1'b1; end
      S_RST_REL: begin out_d.sw_en = 1'b1; out_d.dom_resetb = 1'b1; out_d.busy = 1'b1; end
      S_ON: begin
        out_d.sw_en      = 1'b1;
        out_d.iso_en     = 1'b0;
        out_d.dom_resetb = 1'b1;
        out_d.pwr_on     = 1'b1;
      end
      S_ISO:     begin out_d.sw_en = 1'b1; out_d.dom_resetb = 1'b1; out_d.busy = 1'b1; end
      S_SAVE: begin
        out_d.sw_en      = 1'b1;
        out_d.dom_resetb = 1'b1;
        out_d.save       = 1'b1;
        out_d.busy       = 1'b1;
      end
      S_SW_OFF:  out_d.busy = 1'b1;
      default:   out_d = OUT_OFF;
    endcase
  end

  // Shared saturating counter restarts on every state change
  always_comb begin
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_q   <= OUT_OFF;
      cnt_q   <= '0;
      saved_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      saved_q <= saved_q | (state_d == S_SAVE);
      err_q   <= err_q | timeout_c;
    end
  end

  assign sw_en       = out_q.sw_en;
  assign iso_en      = out_q.iso_en;
  assign save        = out_q.save;
  assign restore     = out_q.restore;
  assign dom_resetb  = out_q.dom_resetb;
  assign pwr_on      = out_q.pwr_on;
  assign busy        = out_q.busy;
  assign err_timeout = err_q;

endmodule
